// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
`default_nettype none

package rf_wr_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/rf_wr_arbiter_fifo.sv
// rf_wr_fifo: buffered side-unit writes with occupancy tracking and a
// parallel register-address compare against the entries still pending.
`default_nettype none

module rf_wr_fifo
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  wr_req_t               i_push_req,
  input  logic                  i_pop,
  output wr_req_t               o_head,
  output logic                  o_empty,
  output logic                  o_full,
  input  logic [REG_ADDR_W-1:0] i_q1,
  input  logic [REG_ADDR_W-1:0] i_q2,
  input  logic [REG_ADDR_W-1:0] i_q3,
  output logic                  o_hit1,
  output logic                  o_hit2,
  output logic                  o_hit3
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_off;
  logic [DEPTH-1:0] w_valid;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_req;
  end

  // An entry is live if it lies within the occupied window and is not the
  // head retiring this cycle (the register file forwards that one itself).
  always_comb begin
    w_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_rd_ptr;
      w_valid[i] = ({1'b0, w_off} < r_count) && !(i_pop && (w_off == '0));
    end
  end

  always_comb begin
    o_hit1 = 1'b0;
    o_hit2 = 1'b0;
    o_hit3 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        if (r_mem[i].addr == i_q1) o_hit1 = 1'b1;
        if (r_mem[i].addr == i_q2) o_hit2 = 1'b1;
        if (r_mem[i].addr == i_q3) o_hit3 = 1'b1;
      end
    end
    if (i_q1 == ZERO_REG) o_hit1 = 1'b0;
    if (i_q2 == ZERO_REG) o_hit2 = 1'b0;
    if (i_q3 == ZERO_REG) o_hit3 = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between WB and a buffered
// side unit. Define RF_ARB_STATS_EN to add grant/starvation statistics outputs.
`default_nettype none

module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wb_wr,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic                  i_b_valid,
  output logic                  o_b_ready,
  input  logic [REG_ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0]     i_b_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr1,
  input  logic [REG_ADDR_W-1:0] i_rd_addr2,
  output logic                  o_busy1,
  output logic                  o_busy2,
  output logic                  o_stall_req,
  output logic                  o_rf_wr,
  output logic [REG_ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0]     o_rf_data
`ifdef RF_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      o_b_grant_cnt,
  output logic [CNT_W-1:0]      o_starve_cnt
`endif
);

  localparam int SCW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SCW-1:0] c_STARVE_MAX = SCW'(STARVE_LIMIT - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1 || CNT_W < 1) begin : g_param_check
    $error("rf_wr_arbiter: illegal parameter value");
  end

  wr_req_t        w_head;
  logic           w_empty;
  logic           w_full;
  logic           w_hit_wb;
  logic           w_wbreq;
  logic           w_head_gnt;
  logic           w_wb_gnt;
  logic           w_bypass;
  logic           w_push;
  logic [SCW-1:0] r_starve;
  logic           r_stall_req;

  assign w_wbreq    = i_wb_wr && (i_wb_addr != ZERO_REG);
  assign w_head_gnt = rst_n && !w_empty && (r_stall_req || !w_wbreq);
  assign w_wb_gnt   = rst_n && w_wbreq && !(r_stall_req && !w_empty);
  assign w_bypass   = rst_n && w_empty && !w_wbreq && i_b_valid && (i_b_addr != ZERO_REG);
  assign w_push     = i_b_valid && !w_full && (i_b_addr != ZERO_REG) && !w_bypass;

  assign o_b_ready   = !w_full;
  assign o_stall_req = r_stall_req;

  always_comb begin
    o_rf_wr   = 1'b0;
    o_rf_addr = ZERO_REG;
    o_rf_data = '0;
    if (w_head_gnt) begin
      o_rf_wr   = 1'b1;
      o_rf_addr = w_head.addr;
      o_rf_data = w_head.data;
    end else if (w_wb_gnt) begin
      o_rf_wr   = 1'b1;
      o_rf_addr = i_wb_addr;
      o_rf_data = i_wb_data;
    end else if (w_bypass) begin
      o_rf_wr   = 1'b1;
      o_rf_addr = i_b_addr;
      o_rf_data = i_b_data;
    end
  end

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_req ({i_b_addr, i_b_data}),
    .i_pop      (w_head_gnt),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .i_q1       (i_rd_addr1),
    .i_q2       (i_rd_addr2),
    .i_q3       (i_wb_addr),
    .o_hit1     (o_busy1),
    .o_hit2     (o_busy2),
    .o_hit3     (w_hit_wb)
  );

  // Starvation: stall is requested on the STARVE_LIMIT-th consecutive cycle
  // the head is passed over, and held until the FIFO has been seen empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve    <= '0;
      r_stall_req <= 1'b0;
    end else begin
      if (w_empty || w_head_gnt) begin
        r_starve <= '0;
      end else if (r_starve != c_STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
      if (w_empty) begin
        r_stall_req <= 1'b0;
      end else if (!w_head_gnt && (r_starve == c_STARVE_MAX)) begin
        r_stall_req <= 1'b1;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [CNT_W-1:0] r_b_grant_cnt;
  logic [CNT_W-1:0] r_starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_grant_cnt <= '0;
      r_starve_cnt  <= '0;
    end else begin
      if ((w_head_gnt || w_bypass) && (r_b_grant_cnt != '1)) r_b_grant_cnt <= r_b_grant_cnt + 1'b1;
      if (r_stall_req && (r_starve_cnt != '1)) r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign o_b_grant_cnt = r_b_grant_cnt;
  assign o_starve_cnt  = r_starve_cnt;
`endif

`ifndef SYNTHESIS
  a_no_wb_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_stall_req && i_wb_wr));
  a_no_wb_to_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wbreq && w_hit_wb));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a queue-based reference model predicts
// each register-file write, and a separate monitor checks the DUT port.
`default_nettype none

module tb_rf_wr_arbiter;
  import rf_wr_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_wr = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic [4:0]  rd1 = '0;
  logic [4:0]  rd2 = '0;
  logic        busy1, busy2, stall_req, rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int errors = 0;
  int checks = 0;

  wr_req_t exp_q[$];
  wr_req_t pend[$];
  bit      m_stall = 1'b0;
  int      m_starve = 0;

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wb_wr     (wb_wr),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_b_valid   (b_valid),
    .o_b_ready   (b_ready),
    .i_b_addr    (b_addr),
    .i_b_data    (b_data),
    .i_rd_addr1  (rd1),
    .i_rd_addr2  (rd2),
    .o_busy1     (busy1),
    .o_busy2     (busy2),
    .o_stall_req (stall_req),
    .o_rf_wr     (rf_wr),
    .o_rf_addr   (rf_addr),
    .o_rf_data   (rf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending_has(input logic [4:0] a, input int skip);
    for (int i = skip; i < pend.size(); i++)
      if (pend[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, predict the write, advance model.
  task automatic step(input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit wbreq, ready, head, wbg, byp, starved, was_empty;
    @(negedge clk);
    if (m_stall || pending_has(wa, 0)) wb = 1'b0;
    wb_wr = wb; wb_addr = wa; wb_data = wd;
    b_valid = bv; b_addr = ba; b_data = bd;
    rd1 = r1; rd2 = r2;
    #1;
    wbreq = wb && (wa != 5'd0);
    ready = pend.size() < DEPTH;
    head = 1'b0; wbg = 1'b0; byp = 1'b0;
    if (m_stall && pend.size() > 0) head = 1'b1;
    else if (wbreq)                 wbg  = 1'b1;
    else if (pend.size() > 0)       head = 1'b1;
    else if (bv && ba != 5'd0)      byp  = 1'b1;
    chk("b_ready", {31'd0, b_ready}, {31'd0, ready});
    chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
    chk("busy1", {31'd0, busy1}, {31'd0, (r1 != 5'd0) && pending_has(r1, head ? 1 : 0)});
    chk("busy2", {31'd0, busy2}, {31'd0, (r2 != 5'd0) && pending_has(r2, head ? 1 : 0)});
    if (wbg)       exp_q.push_back(wr_req_t'{addr: wa, data: wd});
    else if (head) exp_q.push_back(pend[0]);
    else if (byp)  exp_q.push_back(wr_req_t'{addr: ba, data: bd});
    starved   = (pend.size() > 0) && !head;
    was_empty = (pend.size() == 0);
    if (head) void'(pend.pop_front());
    if (bv && ready && ba != 5'd0 && !byp) pend.push_back(wr_req_t'{addr: ba, data: bd});
    if (starved) begin
      m_starve++;
      if (m_starve >= LIMIT) m_stall = 1'b1;
    end else begin
      m_starve = 0;
    end
    if (was_empty) m_stall = 1'b0;
  endtask

  task automatic idle(input int n, input logic [4:0] r1);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  task automatic async_reset(input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    wb_wr = 1'b0; b_valid = 1'b0; rd1 = r1; rd2 = r2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
    pend.delete(); exp_q.delete(); m_stall = 1'b0; m_starve = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle, pop the next predicted write when the DUT writes.
  initial begin
    wr_req_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rf_wr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t", rf_addr, rf_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rf_addr", {27'd0, rf_addr}, {27'd0, e.addr});
          chk("rf_data", rf_data, e.data);
        end
      end else begin
        chk("idle_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("idle_rf_data", rf_data, 32'd0);
      end
    end
  end

  initial begin
    int guard;
    logic [4:0] r1, r2;
    rd1 = 5'd5;
    #3;
    chk("reset_b_ready", {31'd0, b_ready}, 32'd1);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_rf_wr", {31'd0, rf_wr}, 32'd0);
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WB only, then bypass
    step(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0);
    idle(1, 5'd9);

    // Conflict: reg 3 from WB, reg 7 buffered then retired
    step(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd7, 32'h77777777, 5'd7, 5'd0);
    step(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(2, 5'd7);

    // Full FIFO and starvation, then drain
    for (int i = 0; i < 14; i++)
      step(1'b1, 5'd1, $urandom, (i < 5), 5'(20 + i), $urandom, 5'd20, 5'd23);
    idle(8, 5'd23);

    // Zero register on both sides
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
    step(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Three entries buffered with stall asserted, then async reset
    guard = 0;
    while (!(m_stall && pend.size() == 3) && guard < 40) begin
      step(1'b1, 5'd2, $urandom, 1'b1, 5'(24 + (guard % 4)), $urandom, 5'd24, 5'd25);
      guard++;
    end
    chk("stall_with_3_entries", {31'd0, (m_stall && pend.size() == 3)}, 32'd1);
    r1 = (pend.size() > 0) ? pend[0].addr : 5'd24;
    r2 = (pend.size() > 1) ? pend[1].addr : 5'd25;
    async_reset(r1, r2);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0BADCAFE, 5'd12, 5'd0);

    // Randomized traffic honouring the stall and hazard contracts
    for (int n = 0; n < 1500; n++) begin
      logic       rw, rb;
      logic [4:0] ra, rba, q1, q2;
      rw  = ($urandom % 10) < 6;
      ra  = 5'($urandom);
      rb  = $urandom % 2;
      rba = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      q1  = (pend.size() > 0 && $urandom % 2 == 1) ? pend[$urandom % pend.size()].addr : 5'($urandom);
      q2  = 5'($urandom);
      step(rw, ra, $urandom, rb, rba, $urandom, q1, q2);
    end
    idle(12, 5'd0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Arbitrates the single register-file write port (wr/addr3/data3) between two requesters.
- Requester A: pipeline WB stage. Fixed zero latency, never back-pressured.
- Requester B: long-latency side unit (mul/div, uncached load). Uses a valid/ready handshake and is buffered in a small FIFO.
- Sits between the WB stage / side unit and the register file.
- Also reports to ID-stage hazard logic which registers still have buffered B writes pending.

Parameters:
DEPTH, 4, B-side FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles with a non-empty FIFO and no B grant before stall_req is raised
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous active-low reset
wb_wr  in  1  WB write request
wb_addr  in  5  WB destination register
wb_data  in  32  WB write data
b_valid  in  1  side-unit write request
b_ready  out  1  side-unit request accepted this cycle when b_valid && b_ready
b_addr  in  5  side-unit destination register
b_data  in  32  side-unit write data
rd_addr1  in  5  ID-stage source register 1 (hazard query)
rd_addr2  in  5  ID-stage source register 2 (hazard query)
busy1  out  1  rd_addr1 != 0 and matches a buffered B entry
busy2  out  1  same, for rd_addr2
stall_req  out  1  pipeline must hold; WB must not write next cycle
rf_wr  out  1  to register file wr
rf_addr  out  5  to register file addr3
rf_data  out  32  to register file data3

Behaviour:
- Reset (reset=0, async): FIFO empty, read/write pointers 0, starve counter 0, stall_req=0.
- Outputs are combinational from state and inputs: rf_wr=0, rf_addr=0, rf_data=0, b_ready=1, busy1/2=0.
- Effective WB request: wbreq = wb_wr && wb_addr != 0.
- Grant priority, evaluated each cycle, first match wins:
  1. stall_req=1 and FIFO non-empty: drive FIFO head, pop.
  2. wbreq: drive WB, zero latency.
  3. FIFO non-empty: drive FIFO head, pop.
  4. FIFO empty, b_valid, b_addr != 0: drive B input directly (bypass, not enqueued).
  5. Otherwise: rf_wr=0.
- B input with b_addr=0: accepted (b_ready rules apply) and dropped.
- Enqueue: b_valid && b_ready, b_addr != 0, and not consumed by the bypass case.
- b_ready = !full. It does not depend on a same-cycle pop, so there is no pass-through when full.
- Simultaneous push and pop is allowed when not full; occupancy is unchanged.
- FIFO order is strict; writes from B retire in acceptance order.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and its head is not granted.
  - Clears on any head grant or when the FIFO is empty.
  - stall_req is registered: set when the counter reaches STARVE_LIMIT-1 and the head is not granted; cleared the cycle after the FIFO becomes empty.
- Contract: while stall_req=1, wb_wr=0. An assertion flags any violation; WB is then dropped and the head still retires.
- Hazard contract: the pipeline stalls ID while busy1 or busy2 is set. Consequently WB never targets a register that is pending in the FIFO (assertion).
- busy excludes the entry retiring this cycle. The register file forwards the write data for same-cycle reads.
- Reset mid-operation discards all buffered writes.

Optional Feature:
RF_ARB_STATS_EN:
- Adds outputs b_grant_cnt[CNT_W] (FIFO or bypass writes retired) and starve_cnt[CNT_W] (cycles with stall_req=1).
- Both saturate at all-ones and clear on reset.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0, and the wr_req struct {addr, data}.
- One natural sub-module, rf_wr_fifo: pointers, full/empty, head read, and a parallel compare of rd_addr1/2 against valid entries.
- Arbitration and the starve counter stay in the top module.

Test Plan:
- WB only: wb_wr=1, wb_addr=5, wb_data=0x12345678 -> same cycle rf_wr=1, rf_addr=5, rf_data=0x12345678; b_ready=1.
- Bypass: FIFO empty, wb_wr=0, b_valid with addr 9, data 0xA5A5A5A5 -> same cycle rf_addr=9; FIFO stays empty; busy never set.
- Conflict: wb_wr=1 to reg 3 and b_valid to reg 7 in the same cycle -> reg 3 written; reg 7 enqueued; busy1=1 for rd_addr1=7; next idle WB cycle retires reg 7; busy1 drops.
- Full: WB writes every cycle while B pushes 4 entries -> b_ready=0 on the 5th; with STARVE_LIMIT=8, stall_req rises after 8 starved cycles; entries drain in order; stall_req clears after empty.
- Zero register: b_valid with b_addr=0, and wb_wr with wb_addr=0 -> rf_wr=0; FIFO unchanged.
- Async reset with 3 entries buffered and stall_req=1 -> same instant busy1/2=0, stall_req=0, rf_wr=0; after release the first B write bypasses.
